// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: sequences the nco control inputs for a linear frequency
// sweep. It fades amplitude in, steps the phase increment from f_start to
// f_stop with a programmable dwell per step, then fades amplitude out.
// All outputs are registered. Configuration is captured when a sweep starts.
//
// Request protocol: start and abort are single-cycle requests with no ready
// signal. start is accepted only when busy is low. abort is accepted only in
// RAMP_UP or SWEEP. A request that arrives outside its accepting window is
// dropped, not held pending. If start and abort arrive together in IDLE, the
// start is taken. done pulses for exactly one cycle when busy falls.
module nco_sweep_ctrl #(
  parameter int SCALE_INT_WIDTH = 2,
  parameter int SCALE_Q_WIDTH   = 14,
  parameter int DWELL_WIDTH     = 16,
  localparam int SW             = SCALE_INT_WIDTH + SCALE_Q_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   loop_en,
  input  logic [31:0]            f_start,
  input  logic [31:0]            f_stop,
  input  logic [31:0]            f_step,
  input  logic [DWELL_WIDTH-1:0] dwell_cycles,
  input  logic [SW-1:0]          scale_target,
  input  logic [SW-1:0]          ramp_inc,
  input  logic [12:0]            phase_in,
  output logic [31:0]            freq_out,
  output logic [SW-1:0]          scale_out,
  output logic [12:0]            phase_out,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_SWEEP     = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Configuration captured on the start cycle.
  logic [31:0]            fstart_q, fstop_q, fstep_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic [SW-1:0]          target_q, ramp_q;
  logic                   dir_down_q;
  logic                   cfg_load;

  // Registered outputs and dwell counter.
  logic [31:0]            freq_q, freq_d;
  logic [SW-1:0]          scale_q, scale_d;
  logic [12:0]            phase_q, phase_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;

  // Amplitude ramp arithmetic: one extra bit so the sum cannot wrap.
  logic [SW:0]   scale_sum;
  logic [SW-1:0] scale_up_nxt, scale_dn_nxt;
  logic          ramp_up_done, ramp_down_done;

  assign scale_sum    = {1'b0, scale_q} + {1'b0, ramp_q};
  assign scale_up_nxt = ((ramp_q == '0) || (scale_sum >= {1'b0, target_q}))
                        ? target_q : scale_sum[SW-1:0];
  assign scale_dn_nxt = ((ramp_q == '0) || (scale_q <= ramp_q))
                        ? '0 : (scale_q - ramp_q);
  assign ramp_up_done   = (scale_up_nxt == target_q);
  assign ramp_down_done = (scale_dn_nxt == '0);

  // Dwell expiry: a programmed dwell of 0 behaves as 1.
  logic [DWELL_WIDTH-1:0] dwell_last;
  logic                   dwell_expired;

  assign dwell_last    = (dwell_q == '0) ? '0 : (dwell_q - DWELL_WIDTH'(1));
  assign dwell_expired = (cnt_q == dwell_last);

  // Frequency step toward f_stop in 33-bit math, clamped so it never passes f_stop.
  logic [32:0] f_up, f_dn;
  logic [31:0] freq_step_nxt;
  logic        at_stop;

  assign f_up    = {1'b0, freq_q} + {1'b0, fstep_q};
  assign f_dn    = {1'b0, freq_q} - {1'b0, fstep_q};
  assign at_stop = (freq_q == fstop_q);
  assign freq_step_nxt = dir_down_q
    ? ((f_dn[32] || (f_dn[31:0] < fstop_q)) ? fstop_q : f_dn[31:0])
    : ((f_up > {1'b0, fstop_q}) ? fstop_q : f_up[31:0]);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (abort)             state_d = S_RAMP_DOWN;
        else if (ramp_up_done) state_d = S_SWEEP;
      end
      S_SWEEP: begin
        if (abort)                                     state_d = S_RAMP_DOWN;
        else if (dwell_expired && at_stop && !loop_en) state_d = S_RAMP_DOWN;
      end
      S_RAMP_DOWN: begin
        if (ramp_down_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values for each state.
  always_comb begin
    cfg_load = 1'b0;
    freq_d   = freq_q;
    scale_d  = scale_q;
    phase_d  = phase_q;
    cnt_d    = '0;
    done_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        scale_d = '0;
        if (start) begin
          cfg_load = 1'b1;
          freq_d   = f_start;
          phase_d  = phase_in;
        end
      end
      S_RAMP_UP: begin
        if (!abort) scale_d = scale_up_nxt;
      end
      S_SWEEP: begin
        if (!abort) begin
          if (dwell_expired) begin
            if (!at_stop)    freq_d = freq_step_nxt;
            else if (loop_en) freq_d = fstart_q;
          end else begin
            cnt_d = cnt_q + DWELL_WIDTH'(1);
          end
        end
      end
      S_RAMP_DOWN: begin
        scale_d = scale_dn_nxt;
        done_d  = ramp_down_done;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freq_q  <= '0;
      scale_q <= '0;
      phase_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      freq_q  <= freq_d;
      scale_q <= scale_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Configuration capture, frozen for the duration of a sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fstart_q   <= '0;
      fstop_q    <= '0;
      fstep_q    <= '0;
      dwell_q    <= '0;
      target_q   <= '0;
      ramp_q     <= '0;
      dir_down_q <= 1'b0;
    end else if (cfg_load) begin
      fstart_q   <= f_start;
      fstop_q    <= f_stop;
      fstep_q    <= f_step;
      dwell_q    <= dwell_cycles;
      target_q   <= scale_target;
      ramp_q     <= ramp_inc;
      dir_down_q <= (f_stop < f_start);
    end
  end

  assign freq_out  = freq_q;
  assign scale_out = scale_q;
  assign phase_out = phase_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: the reference model builds the whole expected per-cycle
// trace of a sweep from its configuration, and the bench compares the DUT
// against it one cycle at a time.
module tb_nco_sweep_ctrl;

  localparam int CAP = 400;
  localparam logic [1:0] K_IDLE = 2'd0, K_UP = 2'd1, K_SWEEP = 2'd2, K_DOWN = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, abort = 1'b0, loop_en = 1'b0;
  logic [31:0] f_start = '0, f_stop = '0, f_step = '0;
  logic [15:0] dwell_cycles = '0, scale_target = '0, ramp_inc = '0;
  logic [12:0] phase_in = '0;
  logic [31:0] freq_out;
  logic [15:0] scale_out;
  logic [12:0] phase_out;
  logic        busy, done;
  logic [1:0]  dbg_state;

  nco_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step),
    .dwell_cycles(dwell_cycles), .scale_target(scale_target), .ramp_inc(ramp_inc),
    .phase_in(phase_in), .freq_out(freq_out), .scale_out(scale_out),
    .phase_out(phase_out), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Expected trace entries: {state, done, busy, scale[15:0], freq[31:0]}.
  logic [51:0] exp_q[$];

  // Current sweep configuration.
  logic [31:0] c_fs, c_fstop, c_step;
  logic [15:0] c_dwell, c_tgt, c_ramp;
  logic [12:0] c_phase;
  bit          c_loop;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void push(logic [1:0] k, longint f, longint s, logic b, logic d);
    exp_q.push_back({k, d, b, 16'(s), 32'(f)});
  endfunction

  task automatic build_trace(input int abort_req, output int abort_eff);
    longint f, nf, s;
    int     dw, ab;
    bit     fin;
    logic [51:0] last;
    exp_q.delete();
    f = c_fs;
    s = 0;
    push(K_UP, f, 0, 1'b1, 1'b0);
    forever begin
      if (c_ramp == 0) s = c_tgt;
      else s = (s + c_ramp > c_tgt) ? c_tgt : s + c_ramp;
      if (s == c_tgt) break;
      push(K_UP, f, s, 1'b1, 1'b0);
    end
    dw  = (c_dwell == 0) ? 1 : int'(c_dwell);
    fin = 1'b0;
    while (!fin && exp_q.size() < CAP) begin
      for (int i = 0; i < dw; i++) push(K_SWEEP, f, c_tgt, 1'b1, 1'b0);
      if (f == c_fstop) begin
        if (c_loop) f = c_fs;
        else        fin = 1'b1;
      end else if (c_fstop < c_fs) begin
        nf = f - c_step;
        f  = (nf < c_fstop) ? c_fstop : nf;
      end else begin
        nf = f + c_step;
        f  = (nf > c_fstop) ? c_fstop : nf;
      end
    end
    ab = abort_req;
    if (ab == -2) ab = $urandom_range(0, exp_q.size() - 1);
    abort_eff = -1;
    if (ab >= 0 && ab < exp_q.size()) begin
      abort_eff = ab;
      while (exp_q.size() > ab + 1) void'(exp_q.pop_back());
    end
    // Fade out from wherever the sweep stopped, frequency frozen.
    last = exp_q[exp_q.size() - 1];
    f = last[31:0];
    s = last[47:32];
    push(K_DOWN, f, s, 1'b1, 1'b0);
    do begin
      s = (c_ramp == 0 || s <= c_ramp) ? 0 : s - c_ramp;
      push((s == 0) ? K_IDLE : K_DOWN, f, s, s != 0, s == 0);
    end while (s != 0);
    push(K_IDLE, f, 0, 1'b0, 1'b0);
  endtask

  // ---------------- driver / checker for one sweep ----------------
  task automatic run_trace(input string name, input int abort_req, input bit noise,
                           input bit abort_on_start);
    int abort_at;
    logic [51:0] got;
    logic [1:0]  kind;
    build_trace(abort_req, abort_at);
    @(negedge clk);
    f_start = c_fs; f_stop = c_fstop; f_step = c_step;
    dwell_cycles = c_dwell; scale_target = c_tgt; ramp_inc = c_ramp;
    phase_in = c_phase; loop_en = c_loop;
    start = 1'b1;
    abort = abort_on_start;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      got = {dbg_state, done, busy, scale_out, freq_out};
      n_cmp++;
      if (got !== exp_q[i] || phase_out !== c_phase) begin
        n_err++;
        $display("FAIL %s cyc %0d: got st=%0d done=%0d busy=%0d scale=%h freq=%h phase=%h, exp st=%0d done=%0d busy=%0d scale=%h freq=%h phase=%h",
                 name, i, got[51:50], got[49], got[48], got[47:32], got[31:0], phase_out,
                 exp_q[i][51:50], exp_q[i][49], exp_q[i][48], exp_q[i][47:32], exp_q[i][31:0], c_phase);
      end
      abort = (i == abort_at);
      if (noise) begin
        kind = exp_q[i][51:50];
        if (kind != K_IDLE && $urandom_range(0, 3) == 0) start = 1'b1;
        if (kind == K_DOWN && $urandom_range(0, 1) == 0) abort = 1'b1;
        f_start = $urandom(); f_stop = $urandom(); f_step = $urandom();
        dwell_cycles = 16'($urandom()); scale_target = 16'($urandom());
        ramp_inc = 16'($urandom()); phase_in = 13'($urandom());
      end
    end
    start = 1'b0;
    abort = 1'b0;
    loop_en = 1'b0;
  endtask

  task automatic set_cfg(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                         input logic [15:0] dw, input logic [15:0] tg, input logic [15:0] rp,
                         input logic [12:0] ph, input bit lp);
    c_fs = fs; c_fstop = fe; c_step = st; c_dwell = dw;
    c_tgt = tg; c_ramp = rp; c_phase = ph; c_loop = lp;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_cmp++;
    if ({freq_out, scale_out, phase_out, busy, done, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: got freq=%h scale=%h phase=%h busy=%0d done=%0d st=%0d, exp all zero",
               freq_out, scale_out, phase_out, busy, done, dbg_state);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({freq_out, scale_out, phase_out, busy, done, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL reset_release: got freq=%h scale=%h phase=%h busy=%0d done=%0d st=%0d, exp all zero",
               freq_out, scale_out, phase_out, busy, done, dbg_state);
    end
  endtask

  task automatic test_sweep_up();
    set_cfg(32'd100, 32'd400, 32'd100, 16'd3, 16'd16384, 16'd4096, 13'h0a5, 1'b0);
    run_trace("sweep_up", -1, 1'b0, 1'b0);
  endtask

  task automatic test_sweep_down_clamp();
    set_cfg(32'd400, 32'd150, 32'd100, 16'd2, 16'd10000, 16'd3000, 13'h1234, 1'b0);
    run_trace("sweep_down", -1, 1'b0, 1'b0);
  endtask

  task automatic test_no_wrap();
    set_cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 16'd2, 16'd16384, 16'd8192, 13'h0001, 1'b0);
    run_trace("no_wrap", -1, 1'b0, 1'b0);
  endtask

  task automatic test_loop_abort();
    // Index 18 is in the second pass of the loop, at full amplitude.
    set_cfg(32'd100, 32'd400, 32'd100, 16'd3, 16'd16384, 16'd4096, 13'h0777, 1'b1);
    run_trace("loop_abort", 18, 1'b0, 1'b0);
  endtask

  task automatic test_step_zero_abort();
    set_cfg(32'd5, 32'd50, 32'd0, 16'd2, 16'd20000, 16'd7000, 13'h0042, 1'b0);
    run_trace("step_zero", 11, 1'b0, 1'b0);
  endtask

  task automatic test_zero_dwell_ramp();
    set_cfg(32'd10, 32'd40, 32'd10, 16'd0, 16'd12345, 16'd0, 13'h1fff, 1'b0);
    run_trace("zero_dwell_ramp", -1, 1'b0, 1'b0);
  endtask

  task automatic test_start_abort_idle();
    set_cfg(32'd1000, 32'd700, 32'd90, 16'd1, 16'd500, 16'd200, 13'h0100, 1'b0);
    run_trace("start_abort_idle", -1, 1'b0, 1'b1);
  endtask

  task automatic test_ignored_requests();
    logic [51:0] idle_exp, got;
    set_cfg(32'd100, 32'd400, 32'd100, 16'd3, 16'd16384, 16'd4096, 13'h0321, 1'b0);
    run_trace("busy_noise", -1, 1'b1, 1'b0);
    idle_exp = exp_q[exp_q.size() - 1];
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      got = {dbg_state, done, busy, scale_out, freq_out};
      n_cmp++;
      if (got !== idle_exp) begin
        n_err++;
        $display("FAIL abort_in_idle %0d: got %h exp %h", i, got, idle_exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_sweep();
    set_cfg(32'd100, 32'd400, 32'd100, 16'd3, 16'd16384, 16'd4096, 13'h0abc, 1'b0);
    @(negedge clk);
    f_start = c_fs; f_stop = c_fstop; f_step = c_step;
    dwell_cycles = c_dwell; scale_target = c_tgt; ramp_inc = c_ramp;
    phase_in = c_phase; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if ({freq_out, scale_out, phase_out, busy, done, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got freq=%h scale=%h phase=%h busy=%0d done=%0d st=%0d, exp all zero",
               freq_out, scale_out, phase_out, busy, done, dbg_state);
    end
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || scale_out !== '0) begin
        n_err++;
        $display("FAIL reset_after %0d: got done=%0d busy=%0d scale=%h, exp 0/0/0",
                 i, done, busy, scale_out);
      end
    end
  endtask

  task automatic test_random();
    longint stop64;
    int     delta, ab;
    for (int r = 0; r < 40; r++) begin
      c_fs  = $urandom();
      if ($urandom_range(0, 3) == 0) c_fs = 32'hFFFF_FFFF - 32'($urandom_range(0, 500));
      delta = $urandom_range(0, 3000);
      if ($urandom_range(0, 1) == 1) begin
        stop64 = longint'(c_fs) + delta;
        if (stop64 > 64'hFFFF_FFFF) stop64 = 64'hFFFF_FFFF;
      end else begin
        stop64 = longint'(c_fs) - delta;
        if (stop64 < 0) stop64 = 0;
      end
      c_fstop = 32'(stop64);
      c_step  = 32'($urandom_range(delta / 8 + 1, delta + 300));
      c_dwell = 16'($urandom_range(0, 4));
      c_tgt   = 16'($urandom_range(0, 16'hFFFF));
      c_ramp  = ($urandom_range(0, 4) == 0) ? 16'd0
                : 16'($urandom_range(int'(c_tgt) / 6 + 1, 16'hFFFF));
      c_phase = 13'($urandom());
      c_loop  = ($urandom_range(0, 3) == 0);
      if (c_loop) ab = -2;
      else        ab = ($urandom_range(0, 2) == 0) ? -2 : -1;
      run_trace($sformatf("random_%0d", r), ab, bit'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sweep_up();
    test_sweep_down_clamp();
    test_no_wrap();
    test_loop_abort();
    test_step_zero_abort();
    test_zero_dwell_ramp();
    test_start_abort_idle();
    test_ignored_requests();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
